// File: rtl/zap_mult_pkg.sv
// Shared types for the multiplier result stage: queued result entry, flag bit positions, pairing state.
package zap_mult_pkg;

  localparam int MUL_PHY_REGS = 46;
  localparam int MUL_DW       = $clog2(MUL_PHY_REGS);

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [31:0]       rd;
    logic [MUL_DW-1:0] dest;
    logic [3:0]        flags;
    logic              flags_we;
  } mul_entry_t;

  typedef enum logic {
    PAIR_IDLE    = 1'b0,
    PAIR_WAIT_HI = 1'b1
  } pair_state_e;

endpackage

// File: rtl/zap_mult_result_stage_if.sv
// Multiplier-to-ALU result path: producer handshake, control inputs and head-of-queue outputs.
interface zap_mult_result_stage_if #(
  parameter int DW = 6
);
  logic          i_flush;
  logic          i_mul_valid;
  logic          o_mul_ready;
  logic [31:0]   i_mul_rd;
  logic          i_mul_sat;
  logic          i_mul_nozero;
  logic          i_mul_higher;
  logic          i_mul_long;
  logic          i_set_flags;
  logic [DW-1:0] i_dest;
  logic [3:0]    i_cpsr_flags;
  logic          i_clear_q;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_rd;
  logic [DW-1:0] o_dest;
  logic [3:0]    o_flags;
  logic          o_flags_we;
  logic          o_q_sticky;
  logic          o_pair_err;

  // Stage side
  modport slave (
    input  i_flush, i_mul_valid, i_mul_rd, i_mul_sat, i_mul_nozero, i_mul_higher,
           i_mul_long, i_set_flags, i_dest, i_cpsr_flags, i_clear_q, i_ready,
    output o_mul_ready, o_valid, o_rd, o_dest, o_flags, o_flags_we, o_q_sticky, o_pair_err
  );

  // Environment side (multiplier + ALU)
  modport master (
    output i_flush, i_mul_valid, i_mul_rd, i_mul_sat, i_mul_nozero, i_mul_higher,
           i_mul_long, i_set_flags, i_dest, i_cpsr_flags, i_clear_q, i_ready,
    input  o_mul_ready, o_valid, o_rd, o_dest, o_flags, o_flags_we, o_q_sticky, o_pair_err
  );

endinterface

// File: rtl/zap_mult_result_stage_fifo.sv
// Small result queue with registered head and synchronous flush; push visible one cycle later.
// Ready is !full from the registered count only, so a full queue never accepts even while popping.
module zap_mult_skid_fifo
  import zap_mult_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       flush_i,
  input  logic       push_i,
  input  mul_entry_t push_dat_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       vld_o,
  output mul_entry_t head_dat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mul_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign vld_o      = (cnt_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o && !flush_i;
  assign do_pop     = pop_i && vld_o && !flush_i;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/zap_mult_result_stage.sv
// Multiplier result stage: builds N/Z/C/V per result, queues it, pairs long-multiply halves, tracks sticky Q.
// One-cycle push-to-valid latency; o_mul_ready = !full from the registered count.
module zap_mult_result_stage
  import zap_mult_pkg::*;
#(
  parameter int PHY_REGS = MUL_PHY_REGS,
  parameter int DEPTH    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  zap_mult_result_stage_if.slave bus
);

  localparam int DW = $clog2(PHY_REGS);

  mul_entry_t  push_ent;
  mul_entry_t  head_ent;
  logic        fifo_full;
  logic        head_vld;
  logic        take;
  logic        lower_long;
  pair_state_e state_q, state_d;
  logic        err_q, err_d;
  logic        q_q, q_d;

  assign bus.o_mul_ready = !fifo_full;
  assign take            = bus.i_mul_valid && !fifo_full && !bus.i_flush;
  assign lower_long      = bus.i_mul_long && !bus.i_mul_higher;

  // Zero on the upper half only counts when the lower half was zero too.
  always_comb begin
    push_ent               = '0;
    push_ent.rd            = bus.i_mul_rd;
    push_ent.dest          = bus.i_dest;
    push_ent.flags[FLAG_N] = bus.i_mul_rd[31];
    push_ent.flags[FLAG_Z] = (bus.i_mul_rd == 32'd0) && !(bus.i_mul_higher && bus.i_mul_nozero);
    push_ent.flags[FLAG_C] = bus.i_cpsr_flags[FLAG_C];
    push_ent.flags[FLAG_V] = bus.i_cpsr_flags[FLAG_V];
    push_ent.flags_we      = bus.i_set_flags && (!bus.i_mul_long || bus.i_mul_higher);
  end

  zap_mult_skid_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .flush_i    (bus.i_flush),
    .push_i     (bus.i_mul_valid),
    .push_dat_i (push_ent),
    .pop_i      (bus.i_ready),
    .full_o     (fifo_full),
    .vld_o      (head_vld),
    .head_dat_o (head_ent)
  );

  assign bus.o_valid    = head_vld;
  assign bus.o_rd       = head_vld ? head_ent.rd : 32'd0;
  assign bus.o_dest     = head_vld ? head_ent.dest[DW-1:0] : '0;
  assign bus.o_flags    = head_vld ? head_ent.flags : 4'd0;
  assign bus.o_flags_we = head_vld && head_ent.flags_we;
  assign bus.o_q_sticky = q_q;
  assign bus.o_pair_err = err_q;

  // A violating push still moves the FSM to the state that push itself implies.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (bus.i_flush) begin
      state_d = PAIR_IDLE;
    end else if (take) begin
      state_d = lower_long ? PAIR_WAIT_HI : PAIR_IDLE;
      err_d   = (state_q == PAIR_IDLE) ? bus.i_mul_higher : !bus.i_mul_higher;
    end
  end

  always_comb begin
    q_d = q_q;
    if (take && bus.i_mul_sat) q_d = 1'b1;
    else if (bus.i_clear_q)    q_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PAIR_IDLE;
      err_q   <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_zap_mult_result_stage.sv
// Randomized + directed bench for zap_mult_result_stage with a queue-based reference model and scoreboard.
module tb_zap_mult_result_stage;
  import zap_mult_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = MUL_DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  zap_mult_result_stage_if #(.DW(DW)) bus ();

  zap_mult_result_stage #(
    .PHY_REGS (46),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   rd;
    logic [DW-1:0] dest;
    logic [3:0]    flags;
    logic          we;
  } exp_t;

  exp_t sb_q[$];
  int   cnt    = 0;
  bit   q_m    = 0;
  bit   wait_m = 0;
  bit   err_m  = 0;
  bit   mon_en = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model on the clock edge.
  task automatic step(input bit v, input logic [31:0] rd, input bit sat, input bit nz,
                      input bit hi, input bit lg, input bit sf, input logic [DW-1:0] dst,
                      input logic [3:0] cpsr, input bit clr, input bit fl, input bit rdy);
    bit   acc;
    bit   pop;
    exp_t e;
    bus.i_mul_valid  = v;
    bus.i_mul_rd     = rd;
    bus.i_mul_sat    = sat;
    bus.i_mul_nozero = nz;
    bus.i_mul_higher = hi;
    bus.i_mul_long   = lg;
    bus.i_set_flags  = sf;
    bus.i_dest       = dst;
    bus.i_cpsr_flags = cpsr;
    bus.i_clear_q    = clr;
    bus.i_flush      = fl;
    bus.i_ready      = rdy;
    @(posedge clk);
    if (rst) begin
      cnt = 0; q_m = 0; wait_m = 0; err_m = 0;
      sb_q.delete();
    end else begin
      acc = v && (cnt < DEPTH);
      pop = (cnt > 0) && rdy;
      if (fl) begin
        cnt = 0; wait_m = 0; err_m = 0;
        sb_q.delete();
      end else begin
        err_m = 0;
        if (acc) begin
          e.rd    = rd;
          e.dest  = dst;
          e.flags = {rd[31], (rd == 32'd0) && !(hi && nz), cpsr[1], cpsr[0]};
          e.we    = sf && (!lg || hi);
          sb_q.push_back(e);
          err_m  = wait_m ? !hi : hi;
          wait_m = lg && !hi;
        end
        cnt = cnt + int'(acc) - int'(pop);
      end
      if (acc && !fl && sat) q_m = 1;
      else if (clr)          q_m = 0;
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 32'd0, 0, 0, 0, 0, 0, '0, 4'd0, 0, 0, rdy);
  endtask

  // Monitor: mid-cycle, compare control outputs and retire the head on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("o_valid", {31'd0, bus.o_valid}, {31'd0, cnt > 0});
      chk("o_mul_ready", {31'd0, bus.o_mul_ready}, {31'd0, cnt < DEPTH});
      chk("o_q_sticky", {31'd0, bus.o_q_sticky}, {31'd0, q_m});
      chk("o_pair_err", {31'd0, bus.o_pair_err}, {31'd0, err_m});
      if (bus.o_valid && bus.i_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL pop_empty: DUT presented an entry, model queue empty at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("o_rd", bus.o_rd, e.rd);
          chk("o_dest", {{(32-DW){1'b0}}, bus.o_dest}, {{(32-DW){1'b0}}, e.dest});
          chk("o_flags", {28'd0, bus.o_flags}, {28'd0, e.flags});
          chk("o_flags_we", {31'd0, bus.o_flags_we}, {31'd0, e.we});
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    bit          hi;
    bit          lg;
    int          kind;

    idle(0);
    idle(0);
    mon_en = 1;
    #3;
    chk("rst_o_rd", bus.o_rd, 32'd0);
    chk("rst_o_dest", {{(32-DW){1'b0}}, bus.o_dest}, 32'd0);
    chk("rst_o_flags", {28'd0, bus.o_flags}, 32'd0);
    chk("rst_o_flags_we", {31'd0, bus.o_flags_we}, 32'd0);
    rst = 1'b0;

    // Single SMULBB with zero result and C/V set.
    step(1, 32'h0000_0000, 0, 0, 0, 0, 1, 6'd5, 4'b0011, 0, 0, 0);
    idle(1);
    idle(1);
    // UMULL pair: lower then higher with nozero.
    step(1, 32'h0000_0001, 0, 0, 0, 1, 1, 6'd7, 4'b0000, 0, 0, 1);
    step(1, 32'h0000_0000, 0, 1, 1, 1, 1, 6'd8, 4'b0000, 0, 0, 1);
    idle(1);
    idle(1);
    // Backpressure: third push held by upstream until ready.
    step(1, 32'd1, 0, 0, 0, 0, 0, 6'd1, 4'd0, 0, 0, 0);
    step(1, 32'd2, 0, 0, 0, 0, 0, 6'd2, 4'd0, 0, 0, 0);
    step(1, 32'd3, 0, 0, 0, 0, 0, 6'd3, 4'd0, 0, 0, 0);
    step(1, 32'd3, 0, 0, 0, 0, 0, 6'd3, 4'd0, 0, 0, 0);
    step(1, 32'd3, 0, 0, 0, 0, 0, 6'd3, 4'd0, 0, 0, 1);
    step(1, 32'd3, 0, 0, 0, 0, 0, 6'd3, 4'd0, 0, 0, 1);
    idle(1);
    idle(1);
    // Sticky Q: set, set-with-clear, clear alone.
    step(1, 32'h8000_0000, 1, 0, 0, 0, 1, 6'd9, 4'b1111, 0, 0, 1);
    step(1, 32'h1234_5678, 1, 0, 0, 0, 0, 6'd9, 4'b0000, 1, 0, 1);
    idle(1);
    step(0, 32'd0, 0, 0, 0, 0, 0, '0, 4'd0, 1, 0, 1);
    idle(1);
    // Higher push while idle.
    step(1, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 6'd45, 4'b0001, 0, 0, 1);
    idle(1);
    idle(1);
    // Flush mid-pair with two entries queued, then a stray higher.
    step(1, 32'd10, 0, 0, 0, 0, 0, 6'd10, 4'd0, 0, 0, 0);
    step(1, 32'd11, 0, 0, 0, 1, 0, 6'd11, 4'd0, 0, 0, 0);
    step(0, 32'd0, 0, 0, 0, 0, 0, '0, 4'd0, 0, 1, 0);
    step(1, 32'd12, 0, 0, 1, 1, 1, 6'd12, 4'd0, 0, 0, 1);
    idle(1);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      rd   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      kind = $urandom_range(0, 9);
      if (wait_m) hi = (kind < 8);
      else        hi = (kind >= 8);
      lg = hi || ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 9) < 6, rd, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           hi, lg, $urandom_range(0, 1) == 1, DW'($urandom_range(0, 45)),
           4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
    end

    for (int i = 0; i < DEPTH + 3; i++) idle(1);
    chk("drain_empty", sb_q.size(), 32'd0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
